// File: rtl/alu_pkg.sv
// Shared encodings for the accumulator ALU: opcodes, FSM states, flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADC  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_SBC  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/addsub_core.sv
// Combinational adder/subtractor: a + (b ^ {sub}) + cin with carry-out and signed overflow.
module addsub_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   full;

  assign b_x  = b ^ {WIDTH{sub}};
  assign full = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, cin};
  assign sum  = full[WIDTH-1:0];
  assign cout = full[WIDTH];
  // Overflow when both addends share a sign that the sum does not.
  assign ovf  = (a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_accumulator.sv
// Accumulator ALU with valid/ready request and response handshakes.
// Optional ALU_SATURATE_EN clamps ADD/ADC on carry-out and SUB/SBC on borrow.
//
// state   | meaning
// IDLE    | ready for a request; op and operand captured on handshake
// EXEC    | accumulator and flags written at the end of this cycle
// RESP    | result presented until out_ready
module alu_accumulator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             zf,
  output logic             nf,
  output logic             vf
);

  import alu_pkg::*;

  state_t           state, state_n;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] acc, acc_n;
  logic [3:0]       flags, flags_n;

  logic             is_sub, core_cin, core_cout, core_ovf;
  logic [WIDTH-1:0] core_sum;
  logic             c_n, v_n;

  assign is_sub   = (op_q == OP_SUB) || (op_q == OP_SBC);
  // ADC/SBC chain through the stored carry; plain SUB injects the two's-complement +1.
  assign core_cin = ((op_q == OP_ADC) || (op_q == OP_SBC)) ? flags[FLAG_C] : is_sub;

  addsub_core #(.WIDTH(WIDTH)) u_addsub (
    .a    (acc),
    .b    (opnd_q),
    .sub  (is_sub),
    .cin  (core_cin),
    .sum  (core_sum),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  always_comb begin
    acc_n = acc;
    c_n   = flags[FLAG_C];
    v_n   = flags[FLAG_V];
    case (op_q)
      OP_LOAD: acc_n = opnd_q;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        acc_n = core_sum;
        c_n   = core_cout;
        v_n   = core_ovf;
`ifdef ALU_SATURATE_EN
        if (!is_sub && core_cout) begin
          acc_n = '1;
        end else if (is_sub && !core_cout) begin
          acc_n = '0;
        end
`endif
      end
      OP_AND: begin
        acc_n = acc & opnd_q;
        c_n   = 1'b0;
        v_n   = 1'b0;
      end
      OP_OR: begin
        acc_n = acc | opnd_q;
        c_n   = 1'b0;
        v_n   = 1'b0;
      end
      OP_XOR: begin
        acc_n = acc ^ opnd_q;
        c_n   = 1'b0;
        v_n   = 1'b0;
      end
      default: ;
    endcase
    flags_n         = '0;
    flags_n[FLAG_C] = c_n;
    flags_n[FLAG_Z] = (acc_n == '0);
    flags_n[FLAG_N] = acc_n[WIDTH-1];
    flags_n[FLAG_V] = v_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (in_valid)  state_n = ST_EXEC;
      ST_EXEC:                state_n = ST_RESP;
      ST_RESP: if (out_ready) state_n = ST_IDLE;
      default:                state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_q   <= OP_LOAD;
      opnd_q <= '0;
      acc    <= '0;
      flags  <= '0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && in_valid) begin
        op_q   <= op;
        opnd_q <= operand;
      end
      if (state == ST_EXEC) begin
        acc   <= acc_n;
        flags <= flags_n;
      end
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_RESP);
  assign result    = acc;
  assign cf        = flags[FLAG_C];
  assign zf        = flags[FLAG_Z];
  assign nf        = flags[FLAG_N];
  assign vf        = flags[FLAG_V];

endmodule

// File: tb/tb_alu_accumulator.sv
// Scoreboard bench for alu_accumulator (WIDTH=8); honours ALU_SATURATE_EN when defined.
module tb_alu_accumulator;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = 3'd0;
  logic [7:0] operand = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic       cf, zf, nf, vf;
  logic [3:0] dut_fl;

  assign dut_fl = {vf, nf, zf, cf};

  alu_accumulator #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand(operand), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cf(cf), .zf(zf), .nf(nf), .vf(vf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] fl;   // {vf, nf, zf, cf}
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rmode    = 0;  // 0: out_ready=1, 1: random, 2: held low

  logic [7:0] m_acc = 8'd0;
  logic       m_cf = 1'b0, m_vf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out, got no progress expected handshake", name);
  endtask

  // Reference: plain integer arithmetic on the architectural rules.
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] b);
    exp_t e;
    int   ua, ub, sa, sb, full, sres, cin, bin;
    logic [7:0] r;
    ua = int'(m_acc); ub = int'(b);
    sa = int'($signed(m_acc)); sb = int'($signed(b));
    r = m_acc;
    case (o)
      OP_LOAD: r = b;
      OP_ADD, OP_ADC: begin
        cin  = (o == OP_ADC) ? int'(m_cf) : 0;
        full = ua + ub + cin;
        sres = sa + sb + cin;
        m_cf = (full > 255);
        m_vf = (sres > 127) || (sres < -128);
        r    = 8'(full % 256);
`ifdef ALU_SATURATE_EN
        if (m_cf) r = 8'hFF;
`endif
      end
      OP_SUB, OP_SBC: begin
        bin  = (o == OP_SUB) ? 0 : int'(!m_cf);
        full = ua - ub - bin;
        sres = sa - sb - bin;
        m_cf = (full >= 0);
        m_vf = (sres > 127) || (sres < -128);
        r    = 8'((full + 512) % 256);
`ifdef ALU_SATURATE_EN
        if (!m_cf) r = 8'h00;
`endif
      end
      default: begin
        if (o == OP_AND) r = m_acc & b;
        else if (o == OP_OR) r = m_acc | b;
        else r = m_acc ^ b;
        m_cf = 1'b0;
        m_vf = 1'b0;
      end
    endcase
    m_acc = r;
    e.res = r;
    e.fl  = {m_vf, r[7], (r == 8'd0), m_cf};
    return e;
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (rmode == 0) out_ready = 1'b1;
    else if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
    else out_ready = 1'b0;
  end

  // Monitor: pops one expectation for every consumed response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", 32'(result), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", 32'(result), 32'(e.res));
        check("sb_flags", 32'(dut_fl), 32'(e.fl));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin fail_timeout("wait_idle"); return; end
    end
  endtask

  // Issues one request; returns at +1 after the edge where out_valid should rise.
  task automatic issue(input logic [2:0] o, input logic [7:0] b);
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin fail_timeout("issue_wait"); return; end
    end
    op = o; operand = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); operand = 8'($urandom);
    exp_q.push_back(model(o, b));
    check("exec_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("latency_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic check_now(input string name, input logic [7:0] r, input logic [3:0] fl);
    check({name, "_res"}, 32'(result), 32'(r));
    check({name, "_flags"}, 32'(dut_fl), 32'(fl));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hold_r;
    logic [3:0] hold_f;
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(dut_fl), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    issue(OP_LOAD, 8'h7F);
    issue(OP_ADD, 8'h01);
    check_now("t1_add", 8'h80, 4'b1100);

    issue(OP_LOAD, 8'h00);
    issue(OP_SUB, 8'h01);
`ifndef ALU_SATURATE_EN
    check_now("t2_sub", 8'hFF, 4'b0100);
    issue(OP_SBC, 8'h00);
    check_now("t2_sbc", 8'hFE, 4'b0101);
`else
    check_now("t2_sub_sat", 8'h00, 4'b0010);
`endif

    issue(OP_LOAD, 8'hFF);
    issue(OP_ADD, 8'h01);
`ifndef ALU_SATURATE_EN
    check_now("t3_add", 8'h00, 4'b0011);
    issue(OP_ADC, 8'h00);
    check_now("t3_adc", 8'h01, 4'b0000);
`else
    check_now("t3_add_sat", 8'hFF, 4'b0101);
`endif

    // Backpressure with ignored request pulses.
    wait_idle();
    rmode = 2;
    issue(OP_ADD, 8'h23);
    hold_r = result;
    hold_f = dut_fl;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      op = 3'($urandom);
      operand = 8'($urandom);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_result", 32'(result), 32'(hold_r));
      check("bp_flags", 32'(dut_fl), 32'(hold_f));
    end
    in_valid = 1'b0;
    rmode = 0;
    @(posedge clk); #2;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Reset during EXEC discards the request.
    issue(OP_LOAD, 8'h55);
    wait_idle();
    op = OP_ADD; operand = 8'h10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_acc = 8'd0; m_cf = 1'b0; m_vf = 1'b0;
    check("rexec_result", 32'(result), 32'd0);
    check("rexec_flags", 32'(dut_fl), 32'd0);
    check("rexec_out_valid", 32'(out_valid), 32'd0);
    check("rexec_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("rexec_no_resp", 32'(out_valid), 32'd0);

    // Carry survives LOAD, logic op clears it.
    issue(OP_LOAD, 8'hC0);
    issue(OP_ADD, 8'h80);
    check("t6_add_cf", 32'(cf), 32'd1);
    issue(OP_LOAD, 8'hF0);
    check("t6_load_cf", 32'(cf), 32'd1);
    issue(OP_AND, 8'h0F);
    check_now("t6_and", 8'h00, 4'b0010);

    // Randomized traffic with random backpressure.
    rmode = 1;
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), 8'($urandom));
    end
    rmode = 0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
